// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - stream-loaded instruction memory that holds the core in reset until loaded
module imem_stream_loader #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_data,
    input  logic [31:0]          raddr,
    output logic [31:0]          instr,
    output logic                 core_reset,
    output logic                 load_done,
    output logic                 len_error,
    output logic [ADDR_BITS:0]   loaded_count
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_LEN   = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam logic [ADDR_BITS:0] IDX_ONE   = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS:0] IDX_LAST  = (ADDR_BITS+1)'(DEPTH - 1);
    localparam logic [ADDR_BITS:0] IDX_DEPTH = (ADDR_BITS+1)'(DEPTH);

    logic [1:0]         state;
    logic [ADDR_BITS:0] idx;
    logic [ADDR_BITS:0] n_len;
    logic [31:0]        mem [DEPTH];
    logic               xfer;

    // Ready depends only on the registered state, never on in_valid.
    assign in_ready = (state == ST_LEN) || (state == ST_LOAD);
    assign xfer     = in_valid && in_ready;

    // Out-of-range fetches return zero; writes land after the edge, so a same-cycle read sees the old word.
    assign instr = (raddr < 32'(DEPTH)) ? mem[raddr[ADDR_BITS-1:0]] : 32'h0;

    // Sequencer: wipe memory, take the length header, load words, then release the core.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_CLEAR;
            idx          <= '0;
            n_len        <= '0;
            core_reset   <= 1'b1;
            load_done    <= 1'b0;
            len_error    <= 1'b0;
            loaded_count <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= ST_LEN;
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        if (in_data == 32'd0) begin
                            state        <= ST_RUN;
                            core_reset   <= 1'b0;
                            load_done    <= 1'b1;
                            loaded_count <= '0;
                        end else if (in_data > 32'(DEPTH)) begin
                            // Oversized programs are truncated to a full memory; the flag stays set.
                            len_error <= 1'b1;
                            n_len     <= IDX_DEPTH;
                            state     <= ST_LOAD;
                        end else begin
                            n_len <= in_data[ADDR_BITS:0];
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        idx          <= idx + IDX_ONE;
                        loaded_count <= loaded_count + IDX_ONE;
                        if (idx + IDX_ONE == n_len) begin
                            state      <= ST_RUN;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Memory write port: zero fill while clearing, stream words while loading.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[idx[ADDR_BITS-1:0]] <= 32'h0;
            end else if (state == ST_LOAD && xfer) begin
                mem[idx[ADDR_BITS-1:0]] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - randomized self-checking bench for imem_stream_loader
module tb_imem_stream_loader;

    localparam int DEPTH = 256;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] raddr;
    logic [31:0] instr;
    logic        core_reset;
    logic        load_done;
    logic        len_error;
    logic [8:0]  loaded_count;

    imem_stream_loader #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .raddr(raddr),
        .instr(instr),
        .core_reset(core_reset),
        .load_done(load_done),
        .len_error(len_error),
        .loaded_count(loaded_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles since reset, header/length bookkeeping, and a plain memory array.
    bit          m_valid = 0;
    int          since_rst = 0;
    bit          m_hdr = 0;
    bit          m_run = 0;
    bit          m_err = 0;
    int          m_target = 0;
    int          m_count = 0;
    bit          last_acc = 0;
    logic [31:0] m_mem [DEPTH];

    function automatic bit m_ready();
        return m_valid && (since_rst >= DEPTH) && !m_run;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return $urandom();
        if (r == 1) return 32'(DEPTH + int'($urandom_range(0, 60)));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock: advance the model by what the spec says happens at this edge, then re-drive raddr.
    task automatic step();
        bit acc;
        @(posedge clock);
        if (reset) begin
            m_valid   = 1;
            since_rst = 0;
            m_hdr     = 0;
            m_run     = 0;
            m_err     = 0;
            m_target  = 0;
            m_count   = 0;
            last_acc  = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        end else begin
            acc = in_valid && m_ready();
            last_acc = acc;
            if (acc) begin
                if (!m_hdr) begin
                    m_hdr = 1;
                    if (in_data == 32'd0) m_run = 1;
                    else if (in_data > 32'(DEPTH)) begin
                        m_err = 1;
                        m_target = DEPTH;
                    end else m_target = int'(in_data);
                end else begin
                    m_mem[m_count] = in_data;
                    m_count++;
                    if (m_count == m_target) m_run = 1;
                end
            end
            since_rst++;
        end
        #1;
        raddr = rand_addr();
    endtask

    // Compare process: every cycle after the first reset, all outputs against the model.
    always @(negedge clock) begin
        if (m_valid) begin
            chk("in_ready", 64'(in_ready), 64'(m_ready()));
            chk("core_reset", 64'(core_reset), 64'(!m_run));
            chk("load_done", 64'(load_done), 64'(m_run));
            chk("len_error", 64'(len_error), 64'(m_err));
            chk("loaded_count", 64'(loaded_count), 64'(m_count));
            if (since_rst >= DEPTH)
                chk("instr", 64'(instr), 64'((raddr < 32'(DEPTH)) ? m_mem[raddr[7:0]] : 32'h0));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        repeat (DEPTH) step();
    endtask

    // Offer one word until accepted; gap_pct is the chance per cycle of holding in_valid low.
    task automatic send_word(input logic [31:0] w, input int gap_pct);
        bit done;
        done = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
            in_data  = w;
            step();
            done = last_acc;
        end
        in_valid = 1'b0;
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL send_word: word %0h not accepted within budget", w);
        end
    endtask

    task automatic check_addr(input logic [31:0] a, input logic [31:0] exp, input string name);
        raddr = a;
        #1;
        chk(name, 64'(instr), 64'(exp));
    endtask

    initial begin
        logic [31:0] prog5 [5];
        int n;
        prog5[0] = 32'd6494246;
        prog5[1] = 32'd543358986;
        prog5[2] = 32'd2164774;
        prog5[3] = 32'd4329510;
        prog5[4] = 32'd270729219;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = 32'h0;
        raddr = 32'h0;

        // Reset and clear timing.
        step();
        reset = 1'b0;
        #1;
        chk("rst core_reset", 64'(core_reset), 64'd1);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        chk("rst loaded_count", 64'(loaded_count), 64'd0);
        repeat (DEPTH - 1) step();
        chk("clear last in_ready", 64'(in_ready), 64'd0);
        step();
        chk("cycle257 in_ready", 64'(in_ready), 64'd1);
        check_addr(32'd5, 32'h0, "cleared raddr5");

        // Header 5, back-to-back words.
        send_word(32'd5, 0);
        for (int i = 0; i < 5; i++) send_word(prog5[i], 0);
        #1;
        chk("p5 core_reset", 64'(core_reset), 64'd0);
        chk("p5 load_done", 64'(load_done), 64'd1);
        chk("p5 loaded_count", 64'(loaded_count), 64'd5);
        check_addr(32'd4, 32'd270729219, "p5 raddr4");
        check_addr(32'd5, 32'h0, "p5 raddr5");
        check_addr(32'd300, 32'h0, "p5 raddr300");
        check_addr(32'd0, 32'd6494246, "p5 raddr0");

        // Header 3 with an idle cycle after each word.
        do_reset();
        send_word(32'd3, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            send_word(32'h1000 + 32'(i), 0);
            if (i < 2) begin
                #1;
                chk("p3 not done yet", 64'(load_done), 64'd0);
                step();
            end
        end
        #1;
        chk("p3 loaded_count", 64'(loaded_count), 64'd3);
        chk("p3 load_done", 64'(load_done), 64'd1);
        check_addr(32'd2, 32'h1002, "p3 raddr2");

        // Header 0 releases the core immediately; later words are refused.
        do_reset();
        send_word(32'd0, 0);
        #1;
        chk("p0 core_reset", 64'(core_reset), 64'd0);
        in_valid = 1'b1;
        in_data = 32'd77;
        repeat (3) step();
        in_valid = 1'b0;
        chk("p0 in_ready", 64'(in_ready), 64'd0);
        chk("p0 loaded_count", 64'(loaded_count), 64'd0);
        check_addr(32'd0, 32'h0, "p0 raddr0");

        // Header 300 truncates to a full memory.
        do_reset();
        send_word(32'd300, 0);
        #1;
        chk("p300 len_error", 64'(len_error), 64'd1);
        for (int i = 0; i < DEPTH; i++) send_word($urandom(), 20);
        in_valid = 1'b1;
        in_data = 32'hABCD0101;
        repeat (4) step();
        in_valid = 1'b0;
        chk("p300 loaded_count", 64'(loaded_count), 64'd256);
        chk("p300 word257 refused", 64'(in_ready), 64'd0);
        chk("p300 load_done", 64'(load_done), 64'd1);

        // Reset part-way through a load, then reload a single word.
        do_reset();
        send_word(32'd5, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midrst core_reset", 64'(core_reset), 64'd1);
        chk("midrst len_error", 64'(len_error), 64'd0);
        repeat (DEPTH) step();
        check_addr(32'd0, 32'h0, "midrst raddr0");
        send_word(32'd1, 0);
        send_word(32'hDEADBEEF, 0);
        #1;
        check_addr(32'd0, 32'hDEADBEEF, "reload raddr0");

        // Random short programs with random gaps and random fetch addresses.
        for (int p = 0; p < 4; p++) begin
            do_reset();
            n = int'($urandom_range(0, 24));
            send_word(32'(n), 30);
            for (int i = 0; i < n; i++) send_word($urandom(), 40);
            repeat (30) begin
                in_valid = 1'(($urandom_range(0, 1)));
                in_data = $urandom();
                step();
            end
            in_valid = 1'b0;
        end

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
